// File: rtl/dc_pwm_gen.sv
// rtl/dc_pwm_gen.sv - PWM generator with clamped Q16.16 duty command and period-aligned compare update
// Duty commands are clamped, scaled to counts, and applied only at a period boundary.
module dc_pwm_gen #(
  parameter logic        [15:0] PERIOD_CNT = 16'd1000,
  parameter logic signed [31:0] DMIN       = 32'sd3277,
  parameter logic signed [31:0] DMAX       = 32'sd62259,
  parameter logic        [7:0]  SAMPLE_DIV = 8'd4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_duty,
  input  logic        i_duty_valid,
  output logic        o_pwm,
  output logic        o_sample_strobe,
  output logic        o_duty_applied,
  output logic        o_clamped
);

  localparam logic [15:0] CNT_LAST  = PERIOD_CNT - 16'd1;
  localparam logic [15:0] CNT_HALF  = PERIOD_CNT >> 1;
  localparam logic [7:0]  PCNT_LAST = SAMPLE_DIV - 8'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLAMP,
    S_SCALE,
    S_PEND
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_cnt;
  logic [7:0]  r_pcnt;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_pcnt_next;
  logic        w_wrap;

  logic [31:0] r_duty;
  logic [31:0] r_d;
  logic        r_clamp_flag;
  logic [15:0] r_pend_cmp;
  logic [15:0] r_active_cmp;

  logic [47:0] w_product;
  logic [31:0] w_scaled;
  logic [15:0] w_scaled_sat;
  logic        w_load;

  logic        r_pwm;
  logic        r_sample_strobe;
  logic        r_duty_applied;
  logic        r_clamped;

  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_cnt_next  = w_wrap ? 16'd0 : r_cnt + 16'd1;
  assign w_pcnt_next = !w_wrap ? r_pcnt :
                       (r_pcnt == PCNT_LAST) ? 8'd0 : r_pcnt + 8'd1;

  // Unsigned view of the clamped duty; a negative clamp result saturates high.
  assign w_product    = 48'(r_d) * 48'(PERIOD_CNT);
  assign w_scaled     = 32'(w_product >> 16);
  assign w_scaled_sat = (w_scaled > {16'd0, PERIOD_CNT}) ? PERIOD_CNT : w_scaled[15:0];

  // A fresh command overrides the boundary load in the same cycle.
  assign w_load = (r_state == S_PEND) && !i_duty_valid && w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt  <= 16'd0;
      r_pcnt <= 8'd0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_pcnt <= w_pcnt_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_duty_valid) begin
      w_state_next = S_CLAMP;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_CLAMP: w_state_next = S_SCALE;
        S_SCALE: w_state_next = S_PEND;
        S_PEND:  w_state_next = w_wrap ? S_IDLE : S_PEND;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_duty       <= 32'd0;
      r_d          <= 32'd0;
      r_clamp_flag <= 1'b0;
      r_pend_cmp   <= 16'd0;
    end else begin
      if (i_duty_valid) begin
        r_duty <= i_duty;
      end
      if (r_state == S_CLAMP) begin
        if ($signed(r_duty) < DMIN) begin
          r_d          <= DMIN;
          r_clamp_flag <= 1'b1;
        end else if ($signed(r_duty) > DMAX) begin
          r_d          <= DMAX;
          r_clamp_flag <= 1'b1;
        end else begin
          r_d          <= r_duty;
          r_clamp_flag <= 1'b0;
        end
      end
      if (r_state == S_SCALE) begin
        r_pend_cmp <= w_scaled_sat;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_active_cmp    <= 16'd0;
      r_clamped       <= 1'b0;
      r_duty_applied  <= 1'b0;
      r_pwm           <= 1'b0;
      r_sample_strobe <= 1'b0;
    end else begin
      r_duty_applied <= w_load;
      if (w_load) begin
        r_active_cmp <= r_pend_cmp;
        r_clamped    <= r_clamp_flag;
      end
      r_pwm           <= (r_cnt < r_active_cmp);
      // Look ahead one count so the registered strobe lines up with cnt == half.
      r_sample_strobe <= (w_pcnt_next == 8'd0) && (w_cnt_next == CNT_HALF);
    end
  end

  assign o_pwm           = r_pwm;
  assign o_sample_strobe = r_sample_strobe;
  assign o_duty_applied  = r_duty_applied;
  assign o_clamped       = r_clamped;

endmodule

// File: tb/tb_dc_pwm_gen.sv
// tb/tb_dc_pwm_gen.sv - directed self-checking bench for dc_pwm_gen
module tb_dc_pwm_gen;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_duty = 32'd0;
  logic        i_duty_valid = 1'b0;
  logic        o_pwm;
  logic        o_sample_strobe;
  logic        o_duty_applied;
  logic        o_clamped;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;
  int m_pcnt = 0;
  bit mon_en = 1'b0;
  int strb_pos_err = 0;

  dc_pwm_gen dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_duty         (i_duty),
    .i_duty_valid   (i_duty_valid),
    .o_pwm          (o_pwm),
    .o_sample_strobe(o_sample_strobe),
    .o_duty_applied (o_duty_applied),
    .o_clamped      (o_clamped)
  );

  always #5 i_clk = ~i_clk;

  // Reference period/sample counters for 1000-cycle periods and SAMPLE_DIV = 4.
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      m_cnt  <= 0;
      m_pcnt <= 0;
    end else if (m_cnt == 999) begin
      m_cnt  <= 0;
      m_pcnt <= (m_pcnt == 3) ? 0 : m_pcnt + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (mon_en && (o_sample_strobe !== ((m_pcnt == 0) && (m_cnt == 500))))
      strb_pos_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_cycles(input int n, output int highs, output int applies,
                            output int strobes, output int first_strb);
    highs = 0; applies = 0; strobes = 0; first_strb = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (o_pwm === 1'b1) highs++;
      if (o_duty_applied === 1'b1) applies++;
      if (o_sample_strobe === 1'b1) begin
        strobes++;
        if (first_strb == 0) first_strb = i;
      end
    end
  endtask

  task automatic wait_applied(input int bound, output int cyc);
    cyc = 0;
    while (cyc < bound) begin
      tick();
      cyc++;
      if (o_duty_applied === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2000 && m_cnt != v; i++) tick();
  endtask

  task automatic send(input logic [31:0] val);
    i_duty = val;
    i_duty_valid = 1'b1;
    tick();
    i_duty_valid = 1'b0;
  endtask

  task automatic apply_and_measure(input string tag, input logic [31:0] val,
                                   input int exp_cmp, input logic exp_clamp);
    int cyc, highs, applies, strobes, first_strb;
    wait_cnt(100);
    send(val);
    wait_applied(3000, cyc);
    check({tag, "_applied_at_cnt0"}, (cyc > 0 && m_cnt == 0) ? 1 : 0, 1);
    check({tag, "_clamped"}, {31'd0, o_clamped}, {31'd0, exp_clamp});
    run_cycles(1000, highs, applies, strobes, first_strb);
    check({tag, "_high_cycles"}, highs, exp_cmp);
    check({tag, "_extra_applied"}, applies, 0);
  endtask

  initial begin
    int highs, applies, strobes, first_strb, cyc;

    i_reset_n = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    check("rst_pwm", {31'd0, o_pwm}, 0);
    check("rst_strobe", {31'd0, o_sample_strobe}, 0);
    check("rst_applied", {31'd0, o_duty_applied}, 0);
    check("rst_clamped", {31'd0, o_clamped}, 0);
    i_reset_n = 1'b1;

    run_cycles(20000, highs, applies, strobes, first_strb);
    check("free_strobes", strobes, 5);
    check("free_first_strobe", first_strb, 500);
    check("free_pwm_low", highs, 0);
    check("free_no_applied", applies, 0);

    apply_and_measure("half", 32'd32768, 500, 1'b0);
    apply_and_measure("neg_min", 32'hFFFF0000, 50, 1'b1);
    apply_and_measure("over_max", 32'h00020000, 949, 1'b1);

    wait_cnt(100);
    send(32'd16384);
    tick();
    send(32'd49152);
    wait_applied(3000, cyc);
    check("latest_at_cnt0", (cyc > 0 && m_cnt == 0) ? 1 : 0, 1);
    run_cycles(1000, highs, applies, strobes, first_strb);
    check("latest_high_cycles", highs, 750);
    check("latest_single_pulse", applies, 0);

    wait_cnt(996);
    send(32'd16384);
    wait_applied(3000, cyc);
    check("late_ok_latency", cyc + 1, 4);
    wait_cnt(997);
    send(32'd32768);
    wait_applied(3000, cyc);
    check("deferred_latency", cyc + 1, 1003);
    check("deferred_clamped", {31'd0, o_clamped}, 0);

    wait_cnt(100);
    send(32'd32768);
    wait_cnt(500);
    i_reset_n = 1'b0;
    tick();
    check("midrst_pwm", {31'd0, o_pwm}, 0);
    check("midrst_applied", {31'd0, o_duty_applied}, 0);
    check("midrst_clamped", {31'd0, o_clamped}, 0);
    tick();
    i_reset_n = 1'b1;
    run_cycles(1000, highs, applies, strobes, first_strb);
    check("postrst_pwm_low", highs, 0);
    check("postrst_no_applied", applies, 0);
    check("postrst_first_strobe", first_strb, 500);
    run_cycles(1000, highs, applies, strobes, first_strb);
    check("postrst_discarded", applies, 0);

    check("strobe_position", strb_pos_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
